vectored_int: RTL and testbench

Interrupt vector generator for the single-cycle MIPS core with vectored interrupts. It captures completion events from up to four peripherals (`done1`..`done4`) and resolves them by fixed priority. While the controller acknowledges an interrupt, it supplies the jump-table address for the winning source. The datapath's PC mux selects `int_addr` instead of the normal next PC whenever `int_ack` is high. The vectors point at instruction ROM words 124..127, each of which holds a `j` to its ISR.

---
 rtl/vectored_int_if.sv | 30 +++
 rtl/vectored_int.sv | 73 +++++++
 tb/tb_vectored_int.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vectored_int_if.sv
// Bus between the interrupt vector generator and the core controller:
// the four peripheral completion lines, the acknowledge and the vector address.
interface vectored_int_if;
  logic        int_ack;
  logic        done1;
  logic        done2;
  logic        done3;
  logic        done4;
  logic [31:0] int_addr;

  // Controller/peripheral side: drives events and acknowledge, reads the vector.
  modport master (
    output int_ack,
    output done1,
    output done2,
    output done3,
    output done4,
    input  int_addr
  );

  // Vector generator side.
  modport slave (
    input  int_ack,
    input  done1,
    input  done2,
    input  done3,
    input  done4,
    output int_addr
  );
endinterface

// File: rtl/vectored_int.sv
// Vectored interrupt generator: turns rising edges on four done lines into
// pending requests, resolves them by fixed priority (done1 highest) and presents
// the jump-table byte address of the winner while the controller acknowledges.
module vectored_int #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_01F0,
  parameter int          VEC_STRIDE = 4
) (
  input  logic           clk,
  input  logic           reset,
  vectored_int_if.slave  bus
);

  // Bit 0 corresponds to done1 (highest priority), bit 3 to done4.
  logic [3:0] done_in;
  logic [3:0] done_d;
  logic [3:0] pend;
  logic [3:0] rise;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel_idx;
  logic       any_req;

  assign done_in = {bus.done4, bus.done3, bus.done2, bus.done1};

  // The current-cycle edge is folded in so a vector is ready in the same cycle.
  assign rise = done_in & ~done_d;
  assign req  = pend | rise;

  // Fixed-priority pick: lowest index wins; grant is one-hot or zero.
  always_comb begin
    grant   = 4'b0000;
    sel_idx = 2'd0;
    any_req = 1'b0;
    if (req[0]) begin
      grant   = 4'b0001;
      sel_idx = 2'd0;
      any_req = 1'b1;
    end else if (req[1]) begin
      grant   = 4'b0010;
      sel_idx = 2'd1;
      any_req = 1'b1;
    end else if (req[2]) begin
      grant   = 4'b0100;
      sel_idx = 2'd2;
      any_req = 1'b1;
    end else if (req[3]) begin
      grant   = 4'b1000;
      sel_idx = 2'd3;
      any_req = 1'b1;
    end
  end

  // Vector address only while acknowledging a real request; zero otherwise.
  always_comb begin
    bus.int_addr = 32'h0;
    if (bus.int_ack && any_req) begin
      bus.int_addr = VEC_BASE + 32'(VEC_STRIDE) * {30'd0, sel_idx};
    end
  end

  // Edge history and pending flags; the acknowledged winner is consumed,
  // everything else (including fresh edges) is retained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_d <= 4'b0000;
      pend   <= 4'b0000;
    end else begin
      done_d <= done_in;
      pend   <= req & ~(grant & {4{bus.int_ack}});
    end
  end

endmodule

// File: tb/tb_vectored_int.sv
// Directed bench for vectored_int: stimulus pushes expected vector addresses
// into a scoreboard queue; a monitor pops and compares on each checked cycle.
module tb_vectored_int;

  logic clk;
  logic reset;
  logic chk_en;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  vectored_int_if bus ();

  vectored_int #(
    .VEC_BASE   (32'h0000_01F0),
    .VEC_STRIDE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: int_addr=%h with no expected entry", bus.int_addr);
      end else begin
        e = sb.pop_front();
        if (bus.int_addr !== e.exp) begin
          errors++;
          $display("FAIL %s: int_addr got %h expected %h", e.name, bus.int_addr, e.exp);
        end
      end
    end
  end

  task automatic drive(input logic ack, input logic [3:0] d, input logic check,
                       input logic [31:0] exp, input string name);
    exp_t e;
    bus.int_ack = ack;
    bus.done1   = d[0];
    bus.done2   = d[1];
    bus.done3   = d[2];
    bus.done4   = d[3];
    chk_en      = check;
    if (check) begin
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
    end
  endtask

  // One cycle: move inputs just after the rising edge.
  task automatic step(input logic ack, input logic [3:0] d, input logic check,
                      input logic [31:0] exp, input string name);
    @(posedge clk);
    #1;
    drive(ack, d, check, exp, name);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b1, 4'b0000, 1'b1, 32'h0, "reset_state");
    @(posedge clk);
    #3 reset = 1'b1;

    // Pend while not acknowledged, then serve, then nothing left.
    step(1'b0, 4'b0001, 1'b1, 32'h0,   "t1_noack");
    step(1'b1, 4'b0000, 1'b1, 32'h1F0, "t1_grant");
    step(1'b1, 4'b0000, 1'b1, 32'h0,   "t1_consumed");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");

    // Same-cycle edge and acknowledge.
    step(1'b1, 4'b0010, 1'b1, 32'h1F4, "t2_samecycle");
    step(1'b1, 4'b0000, 1'b1, 32'h0,   "t2_consumed");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");

    // All four together, served in priority order.
    step(1'b1, 4'b1111, 1'b1, 32'h1F0, "t3_first");
    step(1'b1, 4'b1111, 1'b1, 32'h1F4, "t3_second");
    step(1'b1, 4'b1111, 1'b1, 32'h1F8, "t3_third");
    step(1'b1, 4'b1111, 1'b1, 32'h1FC, "t3_fourth");
    step(1'b1, 4'b1111, 1'b1, 32'h0,   "t3_empty");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");

    // Level held high yields one event; re-raise yields a new one.
    step(1'b0, 4'b0100, 1'b1, 32'h0,   "t4_noack");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 1'b0, 32'h0, "");
    step(1'b1, 4'b0100, 1'b1, 32'h1F8, "t4_grant");
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0100, 1'b1, 32'h0, "t4_level_no_rereq");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");
    step(1'b1, 4'b0100, 1'b1, 32'h1F8, "t4_reraise");
    step(1'b1, 4'b0000, 1'b1, 32'h0,   "t4_reraise_consumed");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");

    // Reset mid-operation discards a pending event immediately.
    step(1'b0, 4'b1000, 1'b1, 32'h0,   "t5_noack");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 4'b0000, 1'b1, 32'h0, "t5_async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 4'b0000, 1'b1, 32'h0, "t5_after_release");
    step(1'b1, 4'b0000, 1'b1, 32'h0,   "t5_nothing_pending");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");

    // Pending low-priority source pre-empted by a new high-priority edge.
    step(1'b0, 4'b1000, 1'b1, 32'h0,   "t6_noack");
    step(1'b1, 4'b1001, 1'b1, 32'h1F0, "t6_high_first");
    step(1'b1, 4'b1001, 1'b1, 32'h1FC, "t6_low_next");
    step(1'b1, 4'b1001, 1'b1, 32'h0,   "t6_empty");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");

    // Repeat edge while pending merges into one request.
    step(1'b0, 4'b0010, 1'b0, 32'h0,   "");
    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");
    step(1'b0, 4'b0010, 1'b0, 32'h0,   "");
    step(1'b1, 4'b0000, 1'b1, 32'h1F4, "t7_merged_grant");
    step(1'b1, 4'b0000, 1'b1, 32'h0,   "t7_no_second");

    step(1'b0, 4'b0000, 1'b0, 32'h0,   "");
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
